// File: rtl/gorev4_surucu.sv
`default_nettype none
// =============================================================================
// Module   : gorev4_surucu
// Desc     : Feeds a frame of pixels to the histogram core, then collects and
//            checks its 256 result words. GOREV4_TOPLAM_KONTROL_EN adds a
//            count-sum check.
// Revision : 1.0
// =============================================================================
module gorev4_surucu #(
    parameter int PIKSEL_SAYISI  = 76800,
    parameter int PIKSEL_PERIYOT = 6,
    parameter int KELIME_PERIYOT = 6,
    parameter int KELIME_OFSET   = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  piksel_i,
    input  logic        piksel_gecerli_i,
    output logic        piksel_hazir_o,
    output logic        en_o,
    output logic [7:0]  veri_o,
    input  logic        veri_al_i,
    input  logic        veri_gonder_i,
    input  logic [31:0] veri_i,
    input  logic        islem_bitti_i,
    output logic [7:0]  bin_o,
    output logic [23:0] sayi_o,
    output logic        sonuc_gecerli_o,
    output logic        hata_o,
    output logic        toplam_hata_o,
    output logic        bitti_o
);

    typedef enum logic [2:0] {
        BOS   = 3'd0,
        BESLE = 3'd1,
        BEKLE = 3'd2,
        TOPLA = 3'd3,
        BITTI = 3'd4
    } durum_t;

    localparam logic [16:0] c_piksel_son  = 17'(PIKSEL_SAYISI);
    localparam logic [15:0] c_tut_son     = 16'(PIKSEL_PERIYOT - 1);
    localparam logic [15:0] c_kelime_son  = 16'(KELIME_PERIYOT - 1);
    localparam logic [15:0] c_ofset_ilk   = 16'(KELIME_OFSET - 1);
    localparam logic        c_tek_cevrim  = (PIKSEL_PERIYOT == 1);

    durum_t      r_durum;
    logic [15:0] r_tut_say;
    logic [16:0] r_piksel_say;
    logic [15:0] r_kelime_say;
    logic [7:0]  r_beklenen;
    logic        r_vg_d;
    logic        r_hazir;
    logic        r_en;
    logic [7:0]  r_veri;
    logic [7:0]  r_bin;
    logic [23:0] r_sayi;
    logic        r_gecerli;
    logic        r_hata;
    logic        r_bitti;

    logic w_son_piksel;
    logic w_sonraki_son;
    logic w_iptal;
    logic w_ornek;
    logic w_son_kelime;
    logic w_unused;

    assign w_son_piksel  = (r_piksel_say == c_piksel_son);
    assign w_sonraki_son = ((r_piksel_say + 17'd1) == c_piksel_son);
    // A falling veri_gonder_i aborts collection and takes priority over a sample.
    assign w_iptal       = (r_durum == TOPLA) && r_vg_d && !veri_gonder_i;
    assign w_ornek       = (r_durum == TOPLA) && !w_iptal && (r_kelime_say == 16'd0);
    assign w_son_kelime  = w_ornek && (r_beklenen == 8'hFF);

    // The core's pixel request is observed only; feeding never waits on it.
    assign w_unused      = &{1'b0, veri_al_i};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_durum      <= BOS;
            r_tut_say    <= 16'd0;
            r_piksel_say <= 17'd0;
            r_kelime_say <= 16'd0;
            r_beklenen   <= 8'd0;
            r_vg_d       <= 1'b0;
            r_hazir      <= 1'b0;
            r_en         <= 1'b0;
            r_veri       <= 8'd0;
            r_bin        <= 8'd0;
            r_sayi       <= 24'd0;
            r_gecerli    <= 1'b0;
            r_hata       <= 1'b0;
            r_bitti      <= 1'b0;
        end else begin
            r_vg_d    <= veri_gonder_i;
            r_gecerli <= 1'b0;
            case (r_durum)
                BOS: begin
                    r_hazir <= 1'b1;
                    if (piksel_gecerli_i && r_hazir) begin
                        r_veri       <= piksel_i;
                        r_en         <= 1'b1;
                        r_tut_say    <= 16'd0;
                        r_piksel_say <= r_piksel_say + 17'd1;
                        r_hazir      <= c_tek_cevrim && !w_sonraki_son;
                        r_durum      <= BESLE;
                    end
                end
                BESLE: begin
                    if (r_tut_say != c_tut_son) begin
                        r_tut_say <= r_tut_say + 16'd1;
                        r_hazir   <= ((r_tut_say + 16'd1) == c_tut_son) && !w_son_piksel;
                    end else if (w_son_piksel) begin
                        r_durum <= BEKLE;
                        r_en    <= 1'b1;
                        r_hazir <= 1'b0;
                    end else if (piksel_gecerli_i) begin
                        r_veri       <= piksel_i;
                        r_en         <= 1'b1;
                        r_tut_say    <= 16'd0;
                        r_piksel_say <= r_piksel_say + 17'd1;
                        r_hazir      <= c_tek_cevrim && !w_sonraki_son;
                    end else begin
                        // Stalled: hold pixel and counter, keep ready, idle the core.
                        r_en <= 1'b0;
                    end
                end
                BEKLE: begin
                    r_en    <= 1'b1;
                    r_hazir <= 1'b0;
                    if (veri_gonder_i || islem_bitti_i) begin
                        r_durum      <= TOPLA;
                        r_kelime_say <= c_ofset_ilk;
                        r_beklenen   <= 8'd0;
                    end
                end
                TOPLA: begin
                    if (w_iptal) begin
                        r_hata  <= 1'b1;
                        r_en    <= 1'b0;
                        r_bitti <= 1'b1;
                        r_durum <= BITTI;
                    end else if (w_ornek) begin
                        r_bin        <= veri_i[31:24];
                        r_sayi       <= veri_i[23:0];
                        r_gecerli    <= 1'b1;
                        r_beklenen   <= r_beklenen + 8'd1;
                        r_kelime_say <= c_kelime_son;
                        if (veri_i[31:24] != r_beklenen) begin
                            r_hata <= 1'b1;
                        end
                        if (w_son_kelime) begin
                            r_en    <= 1'b0;
                            r_bitti <= 1'b1;
                            r_durum <= BITTI;
                        end
                    end else begin
                        r_kelime_say <= r_kelime_say - 16'd1;
                    end
                end
                BITTI: begin
                    r_en    <= 1'b0;
                    r_hazir <= 1'b0;
                    r_bitti <= 1'b1;
                end
                default: begin
                    r_durum <= BOS;
                end
            endcase
        end
    end

`ifdef GOREV4_TOPLAM_KONTROL_EN
    localparam logic [31:0] c_toplam_hedef = 32'(PIKSEL_SAYISI);

    logic [31:0] r_toplam;
    logic        r_toplam_hata;
    logic [31:0] w_toplam_sonraki;

    assign w_toplam_sonraki = r_toplam + {8'd0, veri_i[23:0]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_toplam      <= 32'd0;
            r_toplam_hata <= 1'b0;
        end else begin
            if (w_ornek) begin
                r_toplam <= w_toplam_sonraki;
            end
            if (w_son_kelime) begin
                r_toplam_hata <= r_toplam_hata | (w_toplam_sonraki != c_toplam_hedef);
            end else if (w_iptal) begin
                r_toplam_hata <= r_toplam_hata | (r_toplam != c_toplam_hedef);
            end
        end
    end

    assign toplam_hata_o = r_toplam_hata;
`else
    assign toplam_hata_o = 1'b0;
`endif

    assign piksel_hazir_o  = r_hazir;
    assign en_o            = r_en;
    assign veri_o          = r_veri;
    assign bin_o           = r_bin;
    assign sayi_o          = r_sayi;
    assign sonuc_gecerli_o = r_gecerli;
    assign hata_o          = r_hata;
    assign bitti_o         = r_bitti;

endmodule
`default_nettype wire

// File: tb/tb_gorev4_surucu.sv
`default_nettype none
// =============================================================================
// Module   : tb_gorev4_surucu
// Desc     : Self-checking bench for gorev4_surucu with a behavioural pixel
//            feed model and a histogram core model.
// Revision : 1.0
// =============================================================================
module tb_gorev4_surucu;

    localparam int N  = 48;
    localparam int P  = 6;
    localparam int KP = 6;
    localparam int OF = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  piksel = 8'd0;
    logic        piksel_gecerli = 1'b0;
    logic        piksel_hazir;
    logic        en;
    logic [7:0]  veri_o;
    logic        veri_al = 1'b0;
    logic        veri_gonder = 1'b0;
    logic [31:0] veri_i = 32'd0;
    logic        islem_bitti = 1'b0;
    logic [7:0]  bin_o;
    logic [23:0] sayi_o;
    logic        sonuc_gecerli;
    logic        hata;
    logic        toplam_hata;
    logic        bitti;

    gorev4_surucu #(
        .PIKSEL_SAYISI (N),
        .PIKSEL_PERIYOT(P),
        .KELIME_PERIYOT(KP),
        .KELIME_OFSET  (OF)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .piksel_i        (piksel),
        .piksel_gecerli_i(piksel_gecerli),
        .piksel_hazir_o  (piksel_hazir),
        .en_o            (en),
        .veri_o          (veri_o),
        .veri_al_i       (veri_al),
        .veri_gonder_i   (veri_gonder),
        .veri_i          (veri_i),
        .islem_bitti_i   (islem_bitti),
        .bin_o           (bin_o),
        .sayi_o          (sayi_o),
        .sonuc_gecerli_o (sonuc_gecerli),
        .hata_o          (hata),
        .toplam_hata_o   (toplam_hata),
        .bitti_o         (bitti)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  pix   [N];
    logic [7:0]  k_bin [256];
    logic [23:0] k_say [256];

    task automatic tik();
        @(posedge clk);
        #1;
    endtask

    task automatic kontrol(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sifirla();
        rst            = 1'b1;
        piksel_gecerli = 1'b1;
        piksel         = 8'hAB;
        veri_gonder    = 1'b0;
        islem_bitti    = 1'b0;
        veri_i         = 32'd0;
        tik();
        tik();
        kontrol("rst_hazir", 32'(piksel_hazir), 32'd0);
        kontrol("rst_en", 32'(en), 32'd0);
        kontrol("rst_veri", 32'(veri_o), 32'd0);
        kontrol("rst_bin", 32'(bin_o), 32'd0);
        kontrol("rst_sayi", 32'(sayi_o), 32'd0);
        kontrol("rst_gecerli", 32'(sonuc_gecerli), 32'd0);
        kontrol("rst_hata", 32'(hata), 32'd0);
        kontrol("rst_toplam", 32'(toplam_hata), 32'd0);
        kontrol("rst_bitti", 32'(bitti), 32'd0);
        rst            = 1'b0;
        piksel_gecerli = 1'b0;
        tik();
    endtask

    task automatic rastgele_kare();
        for (int i = 0; i < N; i++) pix[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic histogram();
        for (int b = 0; b < 256; b++) begin
            k_bin[b] = 8'(b);
            k_say[b] = 24'd0;
        end
        for (int i = 0; i < N; i++) k_say[pix[i]] = k_say[pix[i]] + 24'd1;
    endtask

    // Each accepted pixel is shown for P cycles; ready only once it has aged P cycles.
    task automatic besle(input int kes, input int durak_pik, input bit rastgele);
        int  kabul = 0;
        int  yas   = 0;
        int  durak = 0;
        int  sinir = 0;
        bit  gec;
        bit  hs;
        bit  ex_hazir;
        bit  ex_en;
        logic [7:0] ex_veri;
        while (1) begin
            if (kabul == 0) begin
                ex_hazir = 1'b1;
                ex_en    = 1'b0;
                ex_veri  = 8'd0;
            end else begin
                ex_veri  = pix[kabul-1];
                ex_en    = (yas <= P);
                ex_hazir = (yas >= P) && (kabul < N);
            end
            kontrol("besle_hazir", 32'(piksel_hazir), 32'(ex_hazir));
            kontrol("besle_en", 32'(en), 32'(ex_en));
            kontrol("besle_veri", 32'(veri_o), 32'(ex_veri));
            kontrol("besle_bitti", 32'(bitti), 32'd0);
            if ((kabul == N && yas == P) || (kabul == kes)) begin
                piksel_gecerli = 1'b0;
                break;
            end
            gec = (kabul < N);
            if (gec && rastgele) gec = ($urandom_range(0, 3) != 0);
            if (kabul == durak_pik && ex_hazir && durak < 10) begin
                gec = 1'b0;
                durak++;
            end
            piksel_gecerli = gec;
            piksel         = gec ? pix[kabul] : 8'($urandom_range(0, 255));
            veri_al        = 1'($urandom_range(0, 1));
            hs             = gec && ex_hazir;
            tik();
            if (hs) begin
                kabul++;
                yas = 1;
            end else if (kabul > 0) begin
                yas++;
            end
            sinir++;
            if (sinir > 5000) begin
                checks++;
                errors++;
                $error("FAIL besle_sure observed=%0d expected<=5000", sinir);
                break;
            end
        end
    endtask

    task automatic bekle_kontrol();
        piksel_gecerli = 1'b0;
        tik();
        for (int i = 0; i < 3; i++) begin
            kontrol("bekle_en", 32'(en), 32'd1);
            kontrol("bekle_hazir", 32'(piksel_hazir), 32'd0);
            kontrol("bekle_veri", 32'(veri_o), 32'(pix[N-1]));
            kontrol("bekle_gecerli", 32'(sonuc_gecerli), 32'd0);
            tik();
        end
    endtask

    // Core model: word k is on veri_i for cycles [KP*k, KP*k+KP-1] after the rise.
    task automatic topla(input int dus_kelime);
        int dus_c   = (dus_kelime < 0) ? 32'h3fff_ffff : OF + KP * dus_kelime + 1;
        int son_c   = (dus_kelime < 0) ? OF + 1 + KP * 255 + 6 : dus_c + 15;
        int toplanan = 0;
        bit ex_hata = 1'b0;
        for (int c = 0; c <= son_c; c++) begin
            int k;
            int slot;
            bit strobe;
            bit ex_bitti;
            bit ex_toplam;
            k      = (c - OF - 1) / KP;
            strobe = (c >= OF + 1) && (((c - OF - 1) % KP) == 0) && (k <= 255) && (c <= dus_c);
            if (strobe) begin
                toplanan += int'(k_say[k]);
                if (k_bin[k] != 8'(k)) ex_hata = 1'b1;
            end
            if (c > dus_c) ex_hata = 1'b1;
            ex_bitti = (dus_kelime < 0) ? (c >= OF + 1 + KP * 255) : (c > dus_c);
            ex_toplam = 1'b0;
`ifdef GOREV4_TOPLAM_KONTROL_EN
            ex_toplam = ex_bitti && (toplanan != N);
`endif
            kontrol("topla_gecerli", 32'(sonuc_gecerli), 32'(strobe));
            if (strobe) begin
                kontrol("topla_bin", 32'(bin_o), 32'(k_bin[k]));
                kontrol("topla_sayi", 32'(sayi_o), 32'(k_say[k]));
            end
            kontrol("topla_hata", 32'(hata), 32'(ex_hata));
            kontrol("topla_bitti", 32'(bitti), 32'(ex_bitti));
            kontrol("topla_en", 32'(en), 32'(!ex_bitti));
            kontrol("topla_toplam", 32'(toplam_hata), 32'(ex_toplam));
            slot        = (c / KP > 255) ? 255 : c / KP;
            veri_gonder = (c < dus_c);
            veri_i      = {k_bin[slot], k_say[slot]};
            tik();
        end
        veri_gonder = 1'b0;
    endtask

    initial begin
        sifirla();

        // All-zero frame: bin 0 holds every pixel.
        for (int i = 0; i < N; i++) pix[i] = 8'd0;
        histogram();
        besle(-1, -1, 1'b0);
        bekle_kontrol();
        topla(-1);
        sifirla();

        // Random frame with a 10-cycle valid gap after pixel 5.
        rastgele_kare();
        histogram();
        besle(-1, 6, 1'b1);
        bekle_kontrol();
        topla(-1);
        sifirla();

        // Core reports bin 17 in slot 16.
        rastgele_kare();
        histogram();
        k_bin[16] = 8'd17;
        besle(-1, -1, 1'b1);
        bekle_kontrol();
        topla(-1);
        sifirla();

        // Counts sum to N-1.
        rastgele_kare();
        histogram();
        for (int b = 0; b < 256; b++) begin
            if (k_say[b] != 24'd0) begin
                k_say[b] = k_say[b] - 24'd1;
                break;
            end
        end
        besle(-1, -1, 1'b1);
        bekle_kontrol();
        topla(-1);
        sifirla();

        // Reset mid-feed, then a clean full frame.
        rastgele_kare();
        histogram();
        besle(20, -1, 1'b1);
        sifirla();
        besle(-1, -1, 1'b1);
        bekle_kontrol();
        topla(-1);
        sifirla();

        // veri_gonder_i drops after word 100.
        rastgele_kare();
        histogram();
        besle(-1, -1, 1'b1);
        bekle_kontrol();
        topla(100);
        sifirla();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
